// File: rtl/bus_read_arbiter_n.sv
// ---------------------------------------------------------------------------
// bus_read_arbiter_n
//
// Connects N address-decoded read sources to the CPU memory port. A source
// completes an access in one of two ways:
//   - fixed latency: a per-source wait-state count set at elaboration, or
//   - ready-driven: the source's src_ready handshake, with a timeout.
// Decode faults (no source selected, or more than one) and timeouts end the
// access with bus_error, return all-ones read data and bump a saturating
// fault counter. Every output comes straight from a flop.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high
//   cpu_valid      CPU access request, held until cpu_mem_ready
//   cpu_wstrb      nonzero marks a write; the read data register is then kept
//   src_en         address-decoder selects, one-hot expected
//   src_ready      per-source ready, only looked at for ready-driven sources
//   src_read_data  packed source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cpu_mem_ready  one-cycle completion pulse
//   cpu_read_data  registered read data, valid while cpu_mem_ready is high
//   bus_error      high together with cpu_mem_ready when the access faulted
//   error_count    saturating count of faulted accesses
// ---------------------------------------------------------------------------
module bus_read_arbiter_n #(
  parameter int                         SOURCES      = 8,
  parameter int                         DATA_WIDTH   = 32,
  parameter int                         LAT_W        = 3,
  parameter logic [SOURCES*LAT_W-1:0]   LATENCIES    = '0,
  parameter logic [SOURCES-1:0]         READY_DRIVEN = '0,
  parameter int                         TIMEOUT      = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cpu_valid,
  input  logic [3:0]                      cpu_wstrb,
  input  logic [SOURCES-1:0]              src_en,
  input  logic [SOURCES-1:0]              src_ready,
  input  logic [SOURCES*DATA_WIDTH-1:0]   src_read_data,
  output logic                            cpu_mem_ready,
  output logic [DATA_WIDTH-1:0]           cpu_read_data,
  output logic                            bus_error,
  output logic [7:0]                      error_count
);

  localparam int SEL_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  // The counter serves both the fixed wait states and the timeout, so it
  // must be wide enough for either.
  localparam int CNT_W = (LAT_W > 8) ? LAT_W : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               fault, fault_nxt;

  // Registered output stage
  logic                  vld_p1, vld_nxt;
  logic                  err_p1, err_nxt;
  logic [DATA_WIDTH-1:0] rdata_p1, rdata_nxt;
  logic [7:0]            err_cnt_p1, err_cnt_nxt;

  // Decoder view and per-source lookup tables
  logic [SEL_W-1:0]      dec_idx;
  logic [4:0]            dec_hits;
  logic                  dec_one_hot;
  logic [CNT_W-1:0]      lat_tab  [SOURCES];
  logic [DATA_WIDTH-1:0] data_tab [SOURCES];

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Index of the selected source plus a hit count, so zero-hot and
  // multi-hot selects both show up as "not exactly one".
  always_comb begin
    dec_idx  = '0;
    dec_hits = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (src_en[i]) begin
        dec_idx  = SEL_W'(i);
        dec_hits = dec_hits + 5'd1;
      end
    end
    dec_one_hot = (dec_hits == 5'd1);
  end

  always_comb begin
    for (int i = 0; i < SOURCES; i++) begin
      lat_tab[i]  = CNT_W'(LATENCIES[i*LAT_W +: LAT_W]);
      data_tab[i] = src_read_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---- Stage p0 -> p1: state register and registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= '0;
      cnt        <= '0;
      fault      <= 1'b0;
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
      rdata_p1   <= '0;
      err_cnt_p1 <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      cnt        <= cnt_nxt;
      fault      <= fault_nxt;
      vld_p1     <= vld_nxt;
      err_p1     <= err_nxt;
      rdata_p1   <= rdata_nxt;
      err_cnt_p1 <= err_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    fault_nxt = fault;
    unique case (state)
      IDLE: begin
        if (cpu_valid) begin
          if (dec_one_hot) begin
            sel_nxt   = dec_idx;
            fault_nxt = 1'b0;
            if (READY_DRIVEN[dec_idx]) begin
              cnt_nxt   = '0;
              state_nxt = WAIT;
            end else begin
              cnt_nxt   = lat_tab[dec_idx];
              state_nxt = (lat_tab[dec_idx] == '0) ? RESPOND : WAIT;
            end
          end else begin
            fault_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RESPOND;
          end
        end
      end
      WAIT: begin
        if (READY_DRIVEN[sel]) begin
          // A ready arriving in the last allowed cycle still wins over the timeout.
          if (src_ready[sel]) begin
            state_nxt = RESPOND;
          end else if (cnt == TO_LAST) begin
            cnt_nxt   = cnt + CNT_W'(1);
            fault_nxt = 1'b1;
            state_nxt = RESPOND;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state_nxt = RESPOND;
        end
      end
      RESPOND: state_nxt = HOLDOFF;
      HOLDOFF: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: everything the response cycle shows is computed on the
  // edge entering RESPOND, so the outputs stay purely registered.
  always_comb begin
    vld_nxt     = (state_nxt == RESPOND);
    err_nxt     = vld_nxt & fault_nxt;
    rdata_nxt   = rdata_p1;
    err_cnt_nxt = err_cnt_p1;
    if (vld_nxt) begin
      if (fault_nxt) err_cnt_nxt = sat_inc8(err_cnt_p1);
      if (cpu_wstrb == 4'd0) begin
        rdata_nxt = fault_nxt ? '1 : data_tab[sel_nxt];
      end
    end
  end

  assign cpu_mem_ready = vld_p1;
  assign bus_error     = err_p1;
  assign cpu_read_data = rdata_p1;
  assign error_count   = err_cnt_p1;

endmodule

// File: tb/tb_bus_read_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_bus_read_arbiter_n
//
// Scoreboard bench for bus_read_arbiter_n. Each access pushes its expected
// response (cycle, data, error, fault count) when it is driven; a monitor
// pops and compares on every cpu_mem_ready pulse.
// Source map: 0 L=0, 1 L=1, 2 L=3, 3 L=7, 4 L=0, 5/6 ready-driven, 7 L=0.
// ---------------------------------------------------------------------------
module tb_bus_read_arbiter_n;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TO = 10;
  localparam logic [N*3-1:0] LATS = {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd3, 3'd1, 3'd0};
  localparam logic [N-1:0]   RDRV = 8'b0110_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic            cpu_valid;
  logic [3:0]      cpu_wstrb;
  logic [N-1:0]    src_en;
  logic [N-1:0]    src_ready;
  logic [N*DW-1:0] src_read_data;
  logic            cpu_mem_ready;
  logic [DW-1:0]   cpu_read_data;
  logic            bus_error;
  logic [7:0]      error_count;

  bus_read_arbiter_n #(
    .SOURCES(N), .DATA_WIDTH(DW), .LAT_W(3),
    .LATENCIES(LATS), .READY_DRIVEN(RDRV), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_wstrb(cpu_wstrb),
    .src_en(src_en), .src_ready(src_ready), .src_read_data(src_read_data),
    .cpu_mem_ready(cpu_mem_ready), .cpu_read_data(cpu_read_data),
    .bus_error(bus_error), .error_count(error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  int          model_errs = 0;
  logic [31:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (cpu_mem_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'(cpu_mem_ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
        check("resp_data", cpu_read_data, e.data);
        check("resp_err", 32'(bus_error), 32'(e.err));
        check("resp_errcnt", 32'(error_count), 32'(e.ecnt));
      end
    end
  end

  task automatic push_exp(input int c, input logic [31:0] d, input logic err);
    exp_t e;
    if (err) model_errs = (model_errs == 255) ? 255 : model_errs + 1;
    e.cyc  = c;
    e.data = d;
    e.err  = err;
    e.ecnt = 8'(model_errs);
    sb.push_back(e);
  endtask

  // Runs in the HOLDOFF cycle after the last expected response.
  task automatic finish_access();
    @(posedge clk);
    #2;
    check("ready_one_cycle", 32'(cpu_mem_ready), 32'd0);
    check("rdata_hold", cpu_read_data, last_rdata);
    if (sb.size() != 0) begin
      check("sb_drain", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // One access. rdy0 is driven during the accept cycle (IDLE); (rs,rk) and
  // (ns,nk) raise src_ready[rs]/[ns] in relative cycle rk/nk.
  task automatic run_access(input logic [7:0] en, input logic [3:0] wstrb,
                            input logic [7:0] rdy0,
                            input int rs, input int rk, input int ns, input int nk,
                            input int lat, input logic [31:0] d, input logic err);
    int c0;
    @(negedge clk);
    cpu_valid = 1'b1;
    src_en    = en;
    cpu_wstrb = wstrb;
    src_ready = rdy0;
    c0 = cyc;
    push_exp(c0 + lat, d, err);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      src_ready = '0;
      if (k == lat) begin
        cpu_valid = 1'b0;
        src_en    = '0;
        cpu_wstrb = '0;
      end else begin
        if (rs >= 0 && k == rk) src_ready[rs] = 1'b1;
        if (ns >= 0 && k == nk) src_ready[ns] = 1'b1;
      end
    end
    if (wstrb == 4'd0) last_rdata = d;
    finish_access();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    for (int i = 0; i < N; i++) src_read_data[i*DW +: DW] = 32'hA000_0000 | 32'(i);
    src_read_data[2*DW +: DW] = 32'hCAFE_F00D;
    src_read_data[5*DW +: DW] = 32'h5555_0005;

    // Reset with an active request and every ready asserted
    reset = 1'b1; cpu_valid = 1'b1; cpu_wstrb = '0; src_en = 8'h01; src_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cpu_mem_ready), 32'd0);
    check("rst_err", 32'(bus_error), 32'd0);
    check("rst_rdata", cpu_read_data, 32'd0);
    check("rst_errcnt", 32'(error_count), 32'd0);
    @(negedge clk);
    reset = 1'b0; cpu_valid = 1'b0; src_en = '0; src_ready = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(cpu_mem_ready), 32'd0);
    end

    // Fixed latency: src2 L=3 with src_ready noise that must be ignored
    run_access(8'h04, 4'h0, 8'h04, 2, 1, -1, 0, 4, 32'hCAFE_F00D, 1'b0);
    run_access(8'h01, 4'h0, 8'h00, -1, 0, -1, 0, 1, 32'hA000_0000, 1'b0);
    run_access(8'h02, 4'h0, 8'h00, -1, 0, -1, 0, 2, 32'hA000_0001, 1'b0);
    run_access(8'h08, 4'h0, 8'h00, -1, 0, -1, 0, 8, 32'hA000_0003, 1'b0);

    // Ready-driven: src5 ready in cycle 6, src1 noise in cycle 2, early ready in IDLE
    run_access(8'h20, 4'h0, 8'h20, 5, 6, 1, 2, 7, 32'h5555_0005, 1'b0);
    run_access(8'h40, 4'h0, 8'h00, 6, 1, -1, 0, 2, 32'hA000_0006, 1'b0);
    // Ready in the last cycle before timeout still completes normally
    run_access(8'h20, 4'h0, 8'h00, 5, 10, -1, 0, 11, 32'h5555_0005, 1'b0);

    // Timeout: src6 never ready
    run_access(8'h40, 4'h0, 8'h00, -1, 0, -1, 0, TO + 1, 32'hFFFF_FFFF, 1'b1);
    check("errcnt_after_timeout", 32'(error_count), 32'd1);

    // Decode faults
    run_access(8'h00, 4'h0, 8'h00, -1, 0, -1, 0, 1, 32'hFFFF_FFFF, 1'b1);
    run_access(8'h81, 4'h0, 8'h00, -1, 0, -1, 0, 1, 32'hFFFF_FFFF, 1'b1);

    // Back-to-back with cpu_valid held: pulses 3 cycles apart
    src_read_data[0*DW +: DW] = 32'h5A5A_0000;
    @(negedge clk);
    cpu_valid = 1'b1; src_en = 8'h01; cpu_wstrb = '0; src_ready = '0;
    c0 = cyc;
    for (int j = 0; j < 3; j++) push_exp(c0 + 1 + 3 * j, 32'h5A5A_0000, 1'b0);
    repeat (7) @(negedge clk);
    cpu_valid = 1'b0; src_en = '0;
    last_rdata = 32'h5A5A_0000;
    finish_access();

    // Write keeps the previous read data
    src_read_data[0*DW +: DW] = 32'h1234_5678;
    run_access(8'h01, 4'hF, 8'h00, -1, 0, -1, 0, 1, 32'h5A5A_0000, 1'b0);
    // A following read picks the new value up
    run_access(8'h01, 4'h0, 8'h00, -1, 0, -1, 0, 1, 32'h1234_5678, 1'b0);

    // Saturation of the fault counter
    for (int i = 0; i < 300; i++)
      run_access(8'h00, 4'h0, 8'h00, -1, 0, -1, 0, 1, 32'hFFFF_FFFF, 1'b1);
    check("errcnt_saturated", 32'(error_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
